// File: rtl/vga_sync_rect_pkg.sv
// Shared timing defaults, colour constants and helpers for the VGA rectangle design.
package vga_sync_rect_pkg;

  localparam int unsigned H_ACTIVE_D = 640;
  localparam int unsigned H_FP_D     = 16;
  localparam int unsigned H_SYNC_D   = 96;
  localparam int unsigned H_BP_D     = 48;
  localparam int unsigned H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

  localparam int unsigned V_ACTIVE_D = 480;
  localparam int unsigned V_FP_D     = 10;
  localparam int unsigned V_SYNC_D   = 2;
  localparam int unsigned V_BP_D     = 33;
  localparam int unsigned V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam logic [7:0] RECT_COLOR_D = 8'hE0;
  localparam logic [7:0] BG_COLOR_D   = 8'h03;
  localparam logic [7:0] BLANK_COLOR  = 8'h00;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    coord_t     px;
    coord_t     py;
    logic [7:0] rgb;
  } vga_out_t;

  localparam vga_out_t OUT_RESET = '{
    hsync:       1'b1,
    vsync:       1'b1,
    video_on:    1'b0,
    frame_start: 1'b0,
    px:          '0,
    py:          '0,
    rgb:         BLANK_COLOR
  };

  function automatic logic in_window(coord_t c, int unsigned lo, int unsigned hi);
    return (32'(c) >= lo) && (32'(c) < hi);
  endfunction

  // End bound is 11 bits wide so a span past the raster edge never wraps.
  function automatic logic in_span(coord_t c, coord_t start, coord_t len);
    logic [10:0] stop;
    stop = {1'b0, start} + {1'b0, len};
    return (c >= start) && ({1'b0, c} < stop);
  endfunction

endpackage

// File: rtl/vga_sync_rect_axis_counter.sv
// Wrapping raster axis counter; wrap flags the terminal count combinationally.
module vga_axis_counter
  import vga_sync_rect_pkg::*;
#(
  parameter int unsigned TOTAL = H_TOTAL_D
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t cnt,
  output logic   wrap
);

  assign wrap = (cnt == 10'(TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 10'd1;
    end
  end

endmodule

// File: rtl/vga_sync_rect.sv
// 640x480@60 raster timing with a programmable filled rectangle, RGB332 output.
module vga_sync_rect
  import vga_sync_rect_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_D,
  parameter int unsigned H_FP       = H_FP_D,
  parameter int unsigned H_SYNC     = H_SYNC_D,
  parameter int unsigned H_BP       = H_BP_D,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_D,
  parameter int unsigned V_FP       = V_FP_D,
  parameter int unsigned V_SYNC     = V_SYNC_D,
  parameter int unsigned V_BP       = V_BP_D,
  parameter logic [7:0]  RECT_COLOR = RECT_COLOR_D,
  parameter logic [7:0]  BG_COLOR   = BG_COLOR_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [9:0] rect_x0,
  input  logic [9:0] rect_y0,
  input  logic [9:0] rect_w,
  input  logic [9:0] rect_h,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] px,
  output logic [9:0] py,
  output logic [7:0] rgb,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  coord_t   h, v;
  logic     h_wrap, v_wrap;
  logic     at_origin;
  logic     hit;
  vga_out_t nxt, q;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en),
    .cnt  (h),
    .wrap (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_en & h_wrap),
    .cnt  (v),
    .wrap (v_wrap)
  );

  // Tracks "counters sit at (0,0)" from the wrap flags; equivalent to decoding h==0 && v==0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      at_origin <= 1'b1;
    end else if (pix_en) begin
      at_origin <= h_wrap & v_wrap;
    end
  end

  always_comb begin
    nxt             = OUT_RESET;
    hit             = in_span(h, rect_x0, rect_w) && in_span(v, rect_y0, rect_h);
    nxt.hsync       = !in_window(h, HS_START, HS_END);
    nxt.vsync       = !in_window(v, VS_START, VS_END);
    nxt.video_on    = in_window(h, 0, H_ACTIVE) && in_window(v, 0, V_ACTIVE);
    nxt.frame_start = at_origin;
    nxt.px          = h;
    nxt.py          = v;
    if (nxt.video_on) begin
      nxt.rgb = hit ? RECT_COLOR : BG_COLOR;
    end
  end

  // frame_start is the only output that drops on an idle clk; everything else holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= OUT_RESET;
    end else if (pix_en) begin
      q <= nxt;
    end else begin
      q.frame_start <= 1'b0;
    end
  end

  assign hsync       = q.hsync;
  assign vsync       = q.vsync;
  assign video_on    = q.video_on;
  assign frame_start = q.frame_start;
  assign px          = q.px;
  assign py          = q.py;
  assign rgb         = q.rgb;

endmodule

// File: tb/tb_vga_sync_rect.sv
// Directed bench: full-size raster for line/rectangle/stall/reset, reduced raster for frame timing.
module tb_vga_sync_rect;

  localparam logic [7:0] C_RECT = 8'hE0;
  localparam logic [7:0] C_BG   = 8'h03;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, pen0, hs0, vs0, vo0, fs0;
  logic [9:0] x00, y00, w0, h0, px0, py0;
  logic [7:0] rgb0;
  logic       rst1, pen1, hs1, vs1, vo1, fs1;
  logic [9:0] x01, y01, w1, h1, px1, py1;
  logic [7:0] rgb1;

  vga_sync_rect dut0 (
    .clk(clk), .rst(rst0), .pix_en(pen0),
    .rect_x0(x00), .rect_y0(y00), .rect_w(w0), .rect_h(h0),
    .hsync(hs0), .vsync(vs0), .video_on(vo0), .px(px0), .py(py0),
    .rgb(rgb0), .frame_start(fs0)
  );

  // Reduced raster: 16 clocks/line (sync px 10..12), 10 lines/frame (sync lines 7..8).
  vga_sync_rect #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut1 (
    .clk(clk), .rst(rst1), .pix_en(pen1),
    .rect_x0(x01), .rect_y0(y01), .rect_w(w1), .rect_h(h1),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .px(px1), .py(py1),
    .rgb(rgb1), .frame_start(fs1)
  );

  int nvec = 0;
  int nerr = 0;
  int idx0 = 0;
  int idx1 = 0;

  task automatic step0();
    pen0 = 1'b1;
    @(negedge clk);
    pen0 = 1'b0;
    idx0++;
  endtask

  task automatic step1();
    pen1 = 1'b1;
    @(negedge clk);
    pen1 = 1'b0;
    idx1++;
  endtask

  task automatic advance0(input int x, input int y);
    int target;
    target = y * 800 + x + 1;
    while (idx0 < target) step0();
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; pen0 = 1'b0; pen1 = 1'b0;
    x00 = '0; y00 = '0; w0 = '0; h0 = '0;
    x01 = '0; y01 = '0; w1 = '0; h1 = '0;
    repeat (3) @(negedge clk);
    nvec++; if (hs0 !== 1'b1) begin nerr++; $display("FAIL reset_hsync: got %b want 1", hs0); end
    nvec++; if (vs0 !== 1'b1) begin nerr++; $display("FAIL reset_vsync: got %b want 1", vs0); end
    nvec++; if (vo0 !== 1'b0) begin nerr++; $display("FAIL reset_video_on: got %b want 0", vo0); end
    nvec++; if (fs0 !== 1'b0) begin nerr++; $display("FAIL reset_frame_start: got %b want 0", fs0); end
    nvec++; if (px0 !== 10'd0) begin nerr++; $display("FAIL reset_px: got %0d want 0", px0); end
    nvec++; if (py0 !== 10'd0) begin nerr++; $display("FAIL reset_py: got %0d want 0", py0); end
    nvec++; if (rgb0 !== 8'h00) begin nerr++; $display("FAIL reset_rgb: got %h want 00", rgb0); end
    rst0 = 1'b0;
    idx0 = 0;
  endtask

  task automatic test_first_frame();
    step0();
    nvec++; if (fs0 !== 1'b1) begin nerr++; $display("FAIL first_fs: got %b want 1", fs0); end
    nvec++; if (px0 !== 10'd0 || py0 !== 10'd0) begin nerr++; $display("FAIL first_pos: got (%0d,%0d) want (0,0)", px0, py0); end
    nvec++; if (vo0 !== 1'b1) begin nerr++; $display("FAIL first_video_on: got %b want 1", vo0); end
    nvec++; if (rgb0 !== C_BG) begin nerr++; $display("FAIL first_rgb: got %h want %h", rgb0, C_BG); end
    nvec++; if (hs0 !== 1'b1) begin nerr++; $display("FAIL first_hsync: got %b want 1", hs0); end
    @(negedge clk);
    nvec++; if (fs0 !== 1'b0) begin nerr++; $display("FAIL fs_one_clk: got %b want 0", fs0); end
    nvec++; if (px0 !== 10'd0) begin nerr++; $display("FAIL idle_hold_px: got %0d want 0", px0); end
    repeat (2) @(negedge clk);
    step0();
    nvec++; if (px0 !== 10'd1 || fs0 !== 1'b0) begin nerr++; $display("FAIL second_pix: got px=%0d fs=%b want px=1 fs=0", px0, fs0); end
  endtask

  task automatic test_line_scan();
    int vo_cnt, hs_low, first_low, last_low;
    vo_cnt = 0; hs_low = 0; first_low = -1; last_low = -1;
    while (idx0 < 800) begin
      step0();
      if (vo0) vo_cnt++;
      if (!hs0) begin
        hs_low++;
        if (first_low < 0) first_low = int'(px0);
        last_low = int'(px0);
      end
    end
    nvec++; if (vo_cnt != 638) begin nerr++; $display("FAIL line_video_on_count: got %0d want 638", vo_cnt); end
    nvec++; if (hs_low != 96) begin nerr++; $display("FAIL hsync_width: got %0d want 96", hs_low); end
    nvec++; if (first_low != 656) begin nerr++; $display("FAIL hsync_start: got %0d want 656", first_low); end
    nvec++; if (last_low != 751) begin nerr++; $display("FAIL hsync_end: got %0d want 751", last_low); end
    step0();
    nvec++; if (px0 !== 10'd0 || py0 !== 10'd1) begin nerr++; $display("FAIL line_wrap: got (%0d,%0d) want (0,1)", px0, py0); end
    nvec++; if (hs0 !== 1'b1 || fs0 !== 1'b0) begin nerr++; $display("FAIL line_wrap_flags: got hs=%b fs=%b want hs=1 fs=0", hs0, fs0); end
  endtask

  task automatic test_rect();
    int         xs[7];
    int         ys[7];
    logic [7:0] ex[7];
    xs = '{99, 100, 119, 120, 700, 119, 100};
    ys = '{50, 50, 50, 50, 50, 59, 60};
    ex = '{8'h03, 8'hE0, 8'hE0, 8'h03, 8'h00, 8'hE0, 8'h03};
    x00 = 10'd100; y00 = 10'd50; w0 = 10'd20; h0 = 10'd10;
    for (int i = 0; i < 7; i++) begin
      advance0(xs[i], ys[i]);
      nvec++;
      if (px0 !== 10'(xs[i]) || py0 !== 10'(ys[i])) begin
        nerr++; $display("FAIL rect_pos%0d: got (%0d,%0d) want (%0d,%0d)", i, px0, py0, xs[i], ys[i]);
      end
      nvec++;
      if (rgb0 !== ex[i]) begin
        nerr++; $display("FAIL rect_rgb(%0d,%0d): got %h want %h", xs[i], ys[i], rgb0, ex[i]);
      end
    end
  endtask

  task automatic test_clip();
    int rc, zc, bc, first, last;
    rc = 0; zc = 0; bc = 0; first = -1; last = -1;
    x00 = 10'd630; y00 = 10'd0; w0 = 10'd50; h0 = 10'd480;
    advance0(600, 61);
    repeat (100) begin
      if (rgb0 === C_RECT) begin
        rc++;
        if (first < 0) first = int'(px0);
        last = int'(px0);
      end
      if (px0 >= 10'd640 && px0 < 10'd680 && rgb0 === 8'h00) zc++;
      if (px0 < 10'd630 && rgb0 === C_BG) bc++;
      step0();
    end
    nvec++; if (rc != 10) begin nerr++; $display("FAIL clip_rect_count: got %0d want 10", rc); end
    nvec++; if (first != 630 || last != 639) begin nerr++; $display("FAIL clip_rect_span: got %0d..%0d want 630..639", first, last); end
    nvec++; if (zc != 40) begin nerr++; $display("FAIL clip_blank_count: got %0d want 40", zc); end
    nvec++; if (bc != 30) begin nerr++; $display("FAIL clip_bg_count: got %0d want 30", bc); end
  endtask

  task automatic test_degenerate();
    int rc, bc;
    x00 = 10'd0; y00 = 10'd0; w0 = 10'd0; h0 = 10'd480;
    advance0(0, 62);
    rc = 0; bc = 0;
    repeat (800) begin
      if (rgb0 === C_RECT) rc++;
      if (rgb0 === C_BG) bc++;
      step0();
    end
    nvec++; if (rc != 0) begin nerr++; $display("FAIL zero_w_rect: got %0d want 0", rc); end
    nvec++; if (bc != 640) begin nerr++; $display("FAIL zero_w_bg: got %0d want 640", bc); end
    w0 = 10'd640; h0 = 10'd0;
    rc = 0; bc = 0;
    repeat (800) begin
      if (rgb0 === C_RECT) rc++;
      if (rgb0 === C_BG) bc++;
      step0();
    end
    nvec++; if (rc != 0) begin nerr++; $display("FAIL zero_h_rect: got %0d want 0", rc); end
    nvec++; if (bc != 640) begin nerr++; $display("FAIL zero_h_bg: got %0d want 640", bc); end
  endtask

  task automatic test_stall();
    logic [33:0] snap;
    int          changes;
    advance0(700, 64);
    nvec++; if (hs0 !== 1'b0) begin nerr++; $display("FAIL stall_pre_hsync: got %b want 0", hs0); end
    snap = {hs0, vs0, vo0, fs0, px0, py0, rgb0};
    changes = 0;
    repeat (50) begin
      @(negedge clk);
      if ({hs0, vs0, vo0, fs0, px0, py0, rgb0} !== snap) changes++;
    end
    nvec++; if (changes != 0) begin nerr++; $display("FAIL stall_stable: got %0d changed samples want 0", changes); end
    step0();
    nvec++; if (px0 !== 10'd701 || py0 !== 10'd64) begin nerr++; $display("FAIL stall_resume: got (%0d,%0d) want (701,64)", px0, py0); end
  endtask

  task automatic test_async_reset();
    advance0(300, 65);
    nvec++; if (rgb0 !== C_BG || vo0 !== 1'b1) begin nerr++; $display("FAIL areset_pre: got rgb=%h vo=%b want %h 1", rgb0, vo0, C_BG); end
    #2 rst0 = 1'b1;
    #1;
    nvec++; if (hs0 !== 1'b1 || vs0 !== 1'b1) begin nerr++; $display("FAIL areset_sync: got hs=%b vs=%b want 1 1", hs0, vs0); end
    nvec++; if (rgb0 !== 8'h00 || vo0 !== 1'b0) begin nerr++; $display("FAIL areset_rgb: got rgb=%h vo=%b want 00 0", rgb0, vo0); end
    nvec++; if (px0 !== 10'd0 || py0 !== 10'd0) begin nerr++; $display("FAIL areset_pos: got (%0d,%0d) want (0,0)", px0, py0); end
    @(negedge clk);
    rst0 = 1'b0;
    idx0 = 0;
    step0();
    nvec++; if (px0 !== 10'd0 || py0 !== 10'd0 || fs0 !== 1'b1) begin nerr++; $display("FAIL areset_restart: got (%0d,%0d) fs=%b want (0,0) fs=1", px0, py0, fs0); end
    step0();
    nvec++; if (px0 !== 10'd1 || fs0 !== 1'b0) begin nerr++; $display("FAIL areset_next: got px=%0d fs=%b want px=1 fs=0", px0, fs0); end
  endtask

  task automatic test_small_frame();
    int fs_clks, nfs, f0, f1, f2;
    int vs_low, vs_fx, vs_fy, vo_cnt, vo_late, hs_low, rc, bc;
    fs_clks = 0; nfs = 0; f0 = -1; f1 = -1; f2 = -1;
    vs_low = 0; vs_fx = -1; vs_fy = -1; vo_cnt = 0; vo_late = 0; hs_low = 0; rc = 0; bc = 0;
    x01 = 10'd2; y01 = 10'd1; w1 = 10'd3; h1 = 10'd2;
    rst1 = 1'b0;
    idx1 = 0;
    for (int k = 0; k < 321; k++) begin
      step1();
      if (fs1) begin
        fs_clks++;
        if (nfs == 0) f0 = idx1;
        if (nfs == 1) f1 = idx1;
        if (nfs == 2) f2 = idx1;
        nfs++;
      end
      if (idx1 <= 160) begin
        if (!vs1) begin
          vs_low++;
          if (vs_fx < 0) begin vs_fx = int'(px1); vs_fy = int'(py1); end
        end
        if (!hs1) hs_low++;
        if (vo1) vo_cnt++;
        if (vo1 && py1 >= 10'd6) vo_late++;
        if (rgb1 === C_RECT) rc++;
        if (rgb1 === C_BG) bc++;
      end
      repeat (3) begin
        @(negedge clk);
        if (fs1) fs_clks++;
      end
    end
    nvec++; if (fs_clks != 3) begin nerr++; $display("FAIL small_fs_clks: got %0d want 3", fs_clks); end
    nvec++; if (f0 != 1 || f1 != 161 || f2 != 321) begin nerr++; $display("FAIL small_frame_period: got %0d,%0d,%0d want 1,161,321", f0, f1, f2); end
    nvec++; if (vs_low != 32) begin nerr++; $display("FAIL small_vsync_width: got %0d want 32", vs_low); end
    nvec++; if (vs_fx != 0 || vs_fy != 7) begin nerr++; $display("FAIL small_vsync_start: got (%0d,%0d) want (0,7)", vs_fx, vs_fy); end
    nvec++; if (hs_low != 30) begin nerr++; $display("FAIL small_hsync_count: got %0d want 30", hs_low); end
    nvec++; if (vo_cnt != 48 || vo_late != 0) begin nerr++; $display("FAIL small_video_on: got %0d late=%0d want 48 late=0", vo_cnt, vo_late); end
    nvec++; if (rc != 6 || bc != 42) begin nerr++; $display("FAIL small_rect: got rect=%0d bg=%0d want 6 42", rc, bc); end
    while (idx1 < 443) step1();
    nvec++; if (px1 !== 10'd10 || py1 !== 10'd7 || hs1 !== 1'b0 || vs1 !== 1'b0) begin
      nerr++; $display("FAIL small_pre_reset: got (%0d,%0d) hs=%b vs=%b want (10,7) 0 0", px1, py1, hs1, vs1);
    end
    #2 rst1 = 1'b1;
    #1;
    nvec++; if (hs1 !== 1'b1 || vs1 !== 1'b1 || rgb1 !== 8'h00) begin
      nerr++; $display("FAIL small_areset: got hs=%b vs=%b rgb=%h want 1 1 00", hs1, vs1, rgb1);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_frame();
    test_line_scan();
    test_rect();
    test_clip();
    test_degenerate();
    test_stall();
    test_async_reset();
    test_small_frame();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
